// File: rtl/ccc_rst_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ccc_rst_pkg;

  typedef enum logic [2:0] {
    ST_PWRDN     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_PWRDN_CYCLES = 64;
  localparam int DEF_LOCK_TIMEOUT = 65536;
  localparam int DEF_LOCK_FILTER  = 1024;
  localparam int DEF_CH_GAP       = 16;
  localparam int DEF_CNT_W        = 8;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ccc_rst_sync.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency: 2 clk cycles from d to q.
// Backpressure: none (free-running).
module ccc_rst_sync (
  input  logic clk,
  input  logic arst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous level through two flops; both clear on reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ccc_reset_sequencer.sv
// PLL power-up / lock-filter / staggered channel reset release sequencer.
// Latency: all outputs registered; lock loss drives RST_N low 1 cycle after lock_s falls.
// Backpressure: none; SOFT_RESET always restarts the sequence from PWRDN.
module ccc_reset_sequencer
  import ccc_rst_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int PWRDN_CYCLES = DEF_PWRDN_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_FILTER  = DEF_LOCK_FILTER,
  parameter int CH_GAP       = DEF_CH_GAP,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              ARST_N,
  input  logic              PLL_LOCK,
  input  logic              SOFT_RESET,
  output logic              POWERDOWN_N,
  output logic [NUM_CH-1:0] OUT_EN,
  output logic [NUM_CH-1:0] RST_N,
  output logic              READY,
  output logic [CNT_W-1:0]  LOCK_LOSS_CNT,
  output logic [2:0]        STATE
);

  // One shared timer, restarted on every state entry, wide enough for the longest phase.
  localparam int REL_CYCLES = NUM_CH * CH_GAP;
  localparam int TMR_MAX    = max_of(max_of(PWRDN_CYCLES, LOCK_TIMEOUT),
                                     max_of(LOCK_FILTER, REL_CYCLES));
  localparam int TMR_W      = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TMR_SAT      = TMR_W'(TMR_MAX);
  localparam logic [TMR_W-1:0] PWRDN_LAST   = TMR_W'(PWRDN_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] FILTER_LAST  = TMR_W'(LOCK_FILTER - 1);
  localparam logic [TMR_W-1:0] REL_LAST     = TMR_W'(REL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = '1;

  logic              lock_s;
  state_t            state;
  state_t            nxt;
  logic [TMR_W-1:0]  tmr;
  logic [TMR_W-1:0]  tmr_nxt;
  logic              pd_nxt;
  logic              rdy_nxt;
  logic [NUM_CH-1:0] en_nxt;
  logic [NUM_CH-1:0] rst_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  ccc_rst_sync u_lock_sync (
    .clk    (CLK),
    .arst_n (ARST_N),
    .d      (PLL_LOCK),
    .q      (lock_s)
  );

  assign STATE = state;

  // Next state, timer and next-cycle output values; outputs are decoded from the
  // next state so that the registered outputs line up with the registered state.
  always_comb begin
    nxt     = state;
    tmr_nxt = tmr;
    pd_nxt  = 1'b1;
    rdy_nxt = 1'b0;
    en_nxt  = '0;
    rst_nxt = '0;
    cnt_nxt = LOCK_LOSS_CNT;

    // SOFT_RESET outranks lock loss so a requested restart is never counted as a fault.
    if (SOFT_RESET) begin
      nxt = ST_PWRDN;
    end else begin
      case (state)
        ST_PWRDN:     if (tmr == PWRDN_LAST) nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (lock_s)                     nxt = ST_FILTER;
          else if (tmr == TIMEOUT_LAST)   nxt = ST_PWRDN;
        end
        ST_FILTER: begin
          if (!lock_s)                    nxt = ST_WAIT_LOCK;
          else if (tmr == FILTER_LAST)    nxt = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!lock_s)                    nxt = ST_FAULT;
          else if (tmr == REL_LAST)       nxt = ST_RUN;
        end
        ST_RUN:       if (!lock_s) nxt = ST_FAULT;
        ST_FAULT:     nxt = ST_PWRDN;
        default:      nxt = ST_PWRDN;
      endcase
    end

    // Timer restarts on entry (and on SOFT_RESET in PWRDN), otherwise saturates.
    if (SOFT_RESET || (nxt != state)) begin
      tmr_nxt = '0;
    end else if (tmr != TMR_SAT) begin
      tmr_nxt = tmr + TMR_W'(1);
    end

    case (nxt)
      ST_PWRDN:   pd_nxt = 1'b0;
      ST_RELEASE: begin
        en_nxt = '1;
        // Channel i leaves reset (i+1)*CH_GAP cycles after RELEASE entry.
        for (int i = 0; i < NUM_CH; i++) begin
          rst_nxt[i] = (tmr_nxt >= TMR_W'((i + 1) * CH_GAP));
        end
      end
      ST_RUN: begin
        en_nxt  = '1;
        rst_nxt = '1;
        rdy_nxt = 1'b1;
      end
      ST_FAULT: begin
        if (LOCK_LOSS_CNT != CNT_SAT) cnt_nxt = LOCK_LOSS_CNT + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // State, timer and all outputs are registered; async reset forces the safe state at once.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state         <= ST_PWRDN;
      tmr           <= '0;
      POWERDOWN_N   <= 1'b0;
      OUT_EN        <= '0;
      RST_N         <= '0;
      READY         <= 1'b0;
      LOCK_LOSS_CNT <= '0;
    end else begin
      state         <= nxt;
      tmr           <= tmr_nxt;
      POWERDOWN_N   <= pd_nxt;
      OUT_EN        <= en_nxt;
      RST_N         <= rst_nxt;
      READY         <= rdy_nxt;
      LOCK_LOSS_CNT <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ccc_reset_sequencer.sv
// Directed bench for ccc_reset_sequencer (NUM_CH=3, PWRDN=5, TIMEOUT=40, FILTER=8, GAP=4, CNT_W=2).
// Edge numbers below count rising edges after ARST_N release; checks sample 1ns after an edge.
// Expected values are hand-derived from the sequencing rules.
module tb_ccc_reset_sequencer;

  localparam logic [2:0] S_PWRDN = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_FILT  = 3'd2;
  localparam logic [2:0] S_REL   = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic       CLK = 1'b0;
  logic       ARST_N;
  logic       PLL_LOCK;
  logic       SOFT_RESET;
  logic       POWERDOWN_N;
  logic [2:0] OUT_EN;
  logic [2:0] RST_N;
  logic       READY;
  logic [1:0] LOCK_LOSS_CNT;
  logic [2:0] STATE;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int base = 0;

  ccc_reset_sequencer #(
    .NUM_CH       (3),
    .PWRDN_CYCLES (5),
    .LOCK_TIMEOUT (40),
    .LOCK_FILTER  (8),
    .CH_GAP       (4),
    .CNT_W        (2)
  ) dut (
    .CLK           (CLK),
    .ARST_N        (ARST_N),
    .PLL_LOCK      (PLL_LOCK),
    .SOFT_RESET    (SOFT_RESET),
    .POWERDOWN_N   (POWERDOWN_N),
    .OUT_EN        (OUT_EN),
    .RST_N         (RST_N),
    .READY         (READY),
    .LOCK_LOSS_CNT (LOCK_LOSS_CNT),
    .STATE         (STATE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1ns after edge n (relative to the last reset release).
  task automatic at(input int n);
    while (cyc < base + n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_st(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (STATE !== st && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check(tag, 32'(STATE), 32'(st));
  endtask

  initial begin
    ARST_N = 1'b0;
    PLL_LOCK = 1'b0;
    SOFT_RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_state", 32'(STATE), 32'(S_PWRDN));
    check("rst_pd_n", 32'(POWERDOWN_N), 0);
    check("rst_out_en", 32'(OUT_EN), 0);
    check("rst_rst_n", 32'(RST_N), 0);
    check("rst_ready", 32'(READY), 0);
    check("rst_cnt", 32'(LOCK_LOSS_CNT), 0);
    ARST_N = 1'b1;
    base = cyc;

    // Clean start: PWRDN edges 0..4, WAIT_LOCK from edge 5.
    at(4);  check("cs_pd_low", 32'(POWERDOWN_N), 0);
    at(5);  check("cs_pd_rise", 32'(POWERDOWN_N), 1);
            check("cs_wait", 32'(STATE), 32'(S_WAIT));
    at(10); PLL_LOCK = 1'b1;
    at(12); check("cs_still_wait", 32'(STATE), 32'(S_WAIT));
    at(13); check("cs_filter", 32'(STATE), 32'(S_FILT));
    at(20); check("cs_en_before", 32'(OUT_EN), 0);
    at(21); check("cs_en_after", 32'(OUT_EN), 7);
            check("cs_release", 32'(STATE), 32'(S_REL));
    at(24); check("cs_rst_24", 32'(RST_N), 0);
    at(25); check("cs_rst_25", 32'(RST_N), 1);
    at(28); check("cs_rst_28", 32'(RST_N), 1);
    at(29); check("cs_rst_29", 32'(RST_N), 3);
    at(32); check("cs_rst_32", 32'(RST_N), 3);
            check("cs_rdy_32", 32'(READY), 0);
    at(33); check("cs_rst_33", 32'(RST_N), 7);
            check("cs_rdy_33", 32'(READY), 1);
            check("cs_run", 32'(STATE), 32'(S_RUN));

    // Lock loss in RUN: lock_s falls after edge 37, FAULT at edge 38.
    at(35); PLL_LOCK = 1'b0;
    at(37); check("ll_run_37", 32'(STATE), 32'(S_RUN));
            check("ll_rdy_37", 32'(READY), 1);
    at(38); check("ll_fault", 32'(STATE), 32'(S_FAULT));
            check("ll_rst", 32'(RST_N), 0);
            check("ll_rdy", 32'(READY), 0);
            check("ll_en", 32'(OUT_EN), 0);
            check("ll_cnt", 32'(LOCK_LOSS_CNT), 1);
    at(39); check("ll_pwrdn", 32'(STATE), 32'(S_PWRDN));
            check("ll_pd", 32'(POWERDOWN_N), 0);
    at(44); check("ll_wait", 32'(STATE), 32'(S_WAIT));
            PLL_LOCK = 1'b1;

    // One-cycle glitch during FILTER restarts the filter.
    at(47); check("gl_filter", 32'(STATE), 32'(S_FILT));
    at(49); PLL_LOCK = 1'b0;
    at(50); PLL_LOCK = 1'b1;
    at(51); check("gl_filt_51", 32'(STATE), 32'(S_FILT));
    at(52); check("gl_back_wait", 32'(STATE), 32'(S_WAIT));
            check("gl_en_0", 32'(OUT_EN), 0);
    at(53); check("gl_refilter", 32'(STATE), 32'(S_FILT));
    at(55); check("gl_no_early_rel", 32'(STATE), 32'(S_FILT));
    at(60); check("gl_en_60", 32'(OUT_EN), 0);
    at(61); check("gl_rel", 32'(STATE), 32'(S_REL));
            check("gl_en_61", 32'(OUT_EN), 7);
    at(73); check("gl_run", 32'(STATE), 32'(S_RUN));

    // SOFT_RESET together with lock loss: straight to PWRDN, no count.
    at(75); PLL_LOCK = 1'b0;
    at(77); SOFT_RESET = 1'b1;
    at(78); SOFT_RESET = 1'b0;
            check("sr_pwrdn", 32'(STATE), 32'(S_PWRDN));
            check("sr_cnt", 32'(LOCK_LOSS_CNT), 1);
            check("sr_rst", 32'(RST_N), 0);

    // Timeout retries with lock held low: WAIT_LOCK 83..122, PWRDN 123..127, ...
    at(82);  check("to_pd_82", 32'(POWERDOWN_N), 0);
    at(83);  check("to_pd_83", 32'(POWERDOWN_N), 1);
    at(122); check("to_wait_122", 32'(STATE), 32'(S_WAIT));
    at(123); check("to_pd_123", 32'(POWERDOWN_N), 0);
             check("to_cnt", 32'(LOCK_LOSS_CNT), 1);
    at(127); check("to_pd_127", 32'(POWERDOWN_N), 0);
    at(128); check("to_pd_128", 32'(POWERDOWN_N), 1);
    at(167); check("to_pd_167", 32'(POWERDOWN_N), 1);
    at(168); check("to_pd_168", 32'(POWERDOWN_N), 0);

    // SOFT_RESET inside PWRDN restarts the power-down count.
    at(170); SOFT_RESET = 1'b1;
    at(171); SOFT_RESET = 1'b0;
    at(174); check("srp_hold", 32'(STATE), 32'(S_PWRDN));
    at(175); check("srp_175", 32'(STATE), 32'(S_PWRDN));
    at(176); check("srp_wait", 32'(STATE), 32'(S_WAIT));
             check("srp_cnt", 32'(LOCK_LOSS_CNT), 1);

    // Four more lock losses: the 2-bit count saturates at 3.
    for (int k = 2; k <= 5; k++) begin
      PLL_LOCK = 1'b1;
      wait_st(S_RUN, 60, "sat_run");
      PLL_LOCK = 1'b0;
      wait_st(S_FAULT, 6, "sat_fault");
      check("sat_cnt", 32'(LOCK_LOSS_CNT), (k > 3) ? 3 : k);
      wait_st(S_WAIT, 12, "sat_wait");
    end

    // Async reset mid-RUN forces RST_N low immediately, then restarts from PWRDN.
    PLL_LOCK = 1'b1;
    wait_st(S_RUN, 60, "ar_run");
    #3 ARST_N = 1'b0;
    #1;
    check("ar_rst", 32'(RST_N), 0);
    check("ar_rdy", 32'(READY), 0);
    check("ar_state", 32'(STATE), 32'(S_PWRDN));
    check("ar_cnt", 32'(LOCK_LOSS_CNT), 0);
    @(posedge CLK);
    #1;
    ARST_N = 1'b1;
    base = cyc;
    at(4); check("ar_pwrdn_4", 32'(STATE), 32'(S_PWRDN));
    at(5); check("ar_wait_5", 32'(STATE), 32'(S_WAIT));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ccc_reset_sequencer.md
CCC_RESET_SEQUENCER -- requirements
Module: ccc_reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of PLL output channels managed, legal 1..4.
REQ-002 SHALL have parameter PWRDN_CYCLES, default 64: cycles POWERDOWN_N is held low per power-down pass, legal >=2.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65536: cycles allowed in WAIT_LOCK before a retry.
REQ-004 SHALL have parameter LOCK_FILTER, default 1024: consecutive synchronised-lock cycles required before the lock is accepted.
REQ-005 SHALL have parameter CH_GAP, default 16: cycles between successive channel reset releases, legal >=1.
REQ-006 SHALL have parameter CNT_W, default 8: width of LOCK_LOSS_CNT.
REQ-007 SHALL have one clock and an asynchronous active-low reset, with ports:
  CLK  in  1  free-running fabric clock (the PLL reference clock domain, not a PLL output).
  ARST_N  in  1  asynchronous active-low reset.
  PLL_LOCK  in  1  PLL LOCK, asynchronous to CLK.
  SOFT_RESET  in  1  synchronous request to restart the full sequence.
  POWERDOWN_N  out  1  to PLL POWERDOWN_N.
  OUT_EN  out  NUM_CH  to PLL OUTn_EN.
  RST_N  out  NUM_CH  per-channel active-low reset for the downstream logic.
  READY  out  1  all channels out of reset.
  LOCK_LOSS_CNT  out  CNT_W  saturating count of lock-loss events.
  STATE  out  3  current FSM state encoding.

Function
REQ-008 SHALL synchronise PLL_LOCK through 2 flops (lock_s); all decisions SHALL use lock_s only.
REQ-009 SHALL implement FSM states PWRDN=0, WAIT_LOCK=1, FILTER=2, RELEASE=3, RUN=4, FAULT=5; STATE SHALL present the registered state.
REQ-010 PWRDN: POWERDOWN_N=0, OUT_EN=0, RST_N=0; after PWRDN_CYCLES cycles -> WAIT_LOCK.
REQ-011 WAIT_LOCK: POWERDOWN_N=1; lock_s=1 -> FILTER; timer reaching LOCK_TIMEOUT with lock_s=0 -> PWRDN (retry), LOCK_LOSS_CNT unchanged.
REQ-012 FILTER: counts consecutive lock_s=1 cycles; any lock_s=0 -> WAIT_LOCK with the timeout timer restarted; count reaching LOCK_FILTER -> RELEASE, and OUT_EN becomes all-ones on the same transition.
REQ-013 RELEASE: RST_N[i] SHALL deassert exactly (i+1)*CH_GAP cycles after RELEASE entry; after RST_N[NUM_CH-1] deasserts -> RUN.
REQ-014 RUN: READY=1, all RST_N=1, OUT_EN all-ones.
REQ-015 lock_s=0 in RELEASE or RUN -> FAULT for exactly 1 cycle: RST_N all 0, READY 0, OUT_EN 0, LOCK_LOSS_CNT +1 (saturating at 2^CNT_W-1); then -> PWRDN.
REQ-016 SOFT_RESET=1 in any state other than PWRDN -> PWRDN next cycle, counter unchanged; in PWRDN, SOFT_RESET restarts the PWRDN_CYCLES count.
REQ-017 SOFT_RESET and lock loss in the same cycle: SOFT_RESET wins, no FAULT, no increment.
REQ-018 All outputs SHALL be registered; RST_N assertion SHALL occur on the cycle of leaving RELEASE or RUN, never later than 1 cycle after lock_s falls.
REQ-019 Counters SHALL be sized from parameters with $clog2 and SHALL NOT wrap; each counter resets on state entry.

Reset
REQ-020 On ARST_N=0 asynchronously: state=PWRDN, POWERDOWN_N=0, OUT_EN=0, RST_N=0, READY=0, LOCK_LOSS_CNT=0, sync flops=0, all timers=0.
REQ-021 ARST_N assertion mid-RELEASE or mid-RUN SHALL force RST_N=0 immediately; deassertion SHALL restart from PWRDN.

Structure
REQ-022 Package ccc_rst_pkg SHALL hold the state enum/encoding and default parameter constants.
REQ-023 The 2-flop synchroniser SHALL be a sub-module ccc_rst_sync (async active-low reset, reset value 0).

Verification (NUM_CH=3, PWRDN_CYCLES=5, LOCK_TIMEOUT=40, LOCK_FILTER=8, CH_GAP=4)
REQ-024 Clean start: PLL_LOCK high 10 cycles after ARST_N release -> POWERDOWN_N rises at cycle 5; OUT_EN=3'b111 after 8 filtered cycles; RST_N[0..2] rise 4/8/12 cycles later; READY=1.
REQ-025 Lock glitch: PLL_LOCK low 1 cycle during FILTER -> return to WAIT_LOCK, OUT_EN stays 0, filter restarts from 0.
REQ-026 Timeout: PLL_LOCK held 0 -> POWERDOWN_N pulses low 5 cycles every 40 WAIT_LOCK cycles; LOCK_LOSS_CNT stays 0.
REQ-027 Lock loss in RUN: PLL_LOCK falls -> within 3 cycles RST_N=0, READY=0, STATE=5 for 1 cycle, LOCK_LOSS_CNT=1; full resequence follows.
REQ-028 Simultaneous SOFT_RESET and lock loss in RUN -> STATE=0 next cycle, LOCK_LOSS_CNT unchanged; CNT_W=2 with 5 losses -> count saturates at 3.
